// File: rtl/smp_pkg.sv
// Shared coherence types for the snoop bus and the per-CPU caches:
// MSI block states, address/line geometry and the snoop responder FSM encoding.
package smp_pkg;

  localparam int ADDR_W      = 13;  // bus word address
  localparam int LINE_ADDR_W = 11;  // line address = word address without word select
  localparam int WORD_SEL_W  = 2;
  localparam int WORD_W      = 16;
  localparam int LINE_W      = 64;

  typedef enum logic [1:0] {
    INVALID  = 2'b00,
    SHARED   = 2'b01,
    MODIFIED = 2'b10
  } blk_state_t;

  typedef enum logic [1:0] {
    SNP_IDLE,
    SNP_LOOKUP,
    SNP_WRITEBACK,
    SNP_RESPOND
  } snoop_fsm_t;

  // Word 0 occupies bits 15:0 of the line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0]     line,
                                                  input logic [WORD_SEL_W-1:0] sel);
    return line[WORD_W*int'(sel) +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_snoop_resp.sv
// Per-CPU snoop responder: looks up the local cache for another core's miss,
// writes back a Modified line, answers the bus, then downgrades or invalidates.
module cache_snoop_resp
  import smp_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = LINE_ADDR_W - INDEX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // bus snoop side
  input  logic                   snoop_req,
  input  logic [ADDR_W-1:0]      snoop_addr,
  input  logic                   snoop_inv,
  output logic                   snoop_ack,
  output logic                   snoop_found,
  output logic [1:0]             snoop_state,
  output logic [WORD_W-1:0]      snoop_data,
  output logic                   snoop_busy,
  // cache array lookup
  output logic                   lk_re,
  output logic [INDEX_W-1:0]     lk_idx,
  input  logic [TAG_W-1:0]       lk_tag,
  input  logic [1:0]             lk_state,
  input  logic [LINE_W-1:0]      lk_line,
  // cache state update
  output logic                   upd_we,
  output logic [INDEX_W-1:0]     upd_idx,
  output logic [1:0]             upd_state,
  // data memory write-back
  output logic                   wb_req,
  output logic [LINE_ADDR_W-1:0] wb_addr,
  output logic [LINE_W-1:0]      wb_line,
  input  logic                   wb_rdy
);

  snoop_fsm_t              state_q, state_d;

  logic [LINE_ADDR_W-1:0]  line_addr_q;
  logic [WORD_SEL_W-1:0]   word_sel_q;
  logic                    inv_q;
  logic                    hit_q;
  blk_state_t              blk_q;
  logic [WORD_W-1:0]       word_q;
  logic [LINE_W-1:0]       line_q;
  logic                    busy_q;

  blk_state_t              lk_blk;
  logic                    lk_hit;
  logic                    req_accept;

  assign req_accept = (state_q == SNP_IDLE) && snoop_req;
  assign lk_blk     = blk_state_t'(lk_state);
  assign lk_hit     = (lk_blk != INVALID) &&
                      (lk_tag == line_addr_q[LINE_ADDR_W-1 -: TAG_W]);

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SNP_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: a default on entry to every combinational block keeps each output
    // assigned on all paths, so no latches are inferred.
    state_d = state_q;
    unique case (state_q)
      SNP_IDLE:      if (snoop_req) state_d = SNP_LOOKUP;
      SNP_LOOKUP:    state_d = (lk_hit && lk_blk == MODIFIED) ? SNP_WRITEBACK : SNP_RESPOND;
      SNP_WRITEBACK: if (wb_rdy) state_d = SNP_RESPOND;
      SNP_RESPOND:   state_d = SNP_IDLE;
      default:       state_d = SNP_IDLE;
    endcase
  end

  // Request fields are captured once in IDLE; bus changes while busy are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_addr_q <= '0;
      word_sel_q  <= '0;
      inv_q       <= 1'b0;
    end else if (req_accept) begin
      line_addr_q <= snoop_addr[ADDR_W-1:WORD_SEL_W];
      word_sel_q  <= snoop_addr[WORD_SEL_W-1:0];
      inv_q       <= snoop_inv;
    end
  end

  // Lookup result: a miss reports INVALID and a zero word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= 1'b0;
      blk_q  <= INVALID;
      word_q <= '0;
      line_q <= '0;
    end else if (state_q == SNP_LOOKUP) begin
      hit_q  <= lk_hit;
      blk_q  <= lk_hit ? lk_blk : INVALID;
      word_q <= lk_hit ? line_word(lk_line, word_sel_q) : '0;
      line_q <= lk_line;
    end
  end

  // Busy is registered so the local MEM-stage stall sees a clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= (state_d != SNP_IDLE);
  end

  assign snoop_busy = busy_q;

  always_comb begin
    lk_re       = 1'b0;
    lk_idx      = '0;
    wb_req      = 1'b0;
    wb_addr     = '0;
    wb_line     = '0;
    snoop_ack   = 1'b0;
    snoop_found = 1'b0;
    snoop_state = INVALID;
    snoop_data  = '0;
    upd_we      = 1'b0;
    upd_idx     = '0;
    upd_state   = INVALID;
    unique case (state_q)
      SNP_IDLE: begin
        lk_re  = snoop_req;
        lk_idx = snoop_req ? snoop_addr[WORD_SEL_W +: INDEX_W] : '0;
      end
      SNP_WRITEBACK: begin
        wb_req  = 1'b1;
        wb_addr = line_addr_q;
        wb_line = line_q;
      end
      SNP_RESPOND: begin
        snoop_ack   = 1'b1;
        snoop_found = hit_q;
        snoop_state = blk_q;
        snoop_data  = word_q;
        // Invalidate wins; a Modified read hit drops to Shared after its write-back.
        if (hit_q && (inv_q || blk_q == MODIFIED)) begin
          upd_we    = 1'b1;
          upd_idx   = line_addr_q[INDEX_W-1:0];
          upd_state = inv_q ? INVALID : SHARED;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_snoop_resp.sv
// Self-checking bench for cache_snoop_resp: a behavioural cache array around the
// DUT, directed scenarios and randomized snoops against an MSI reference model.
module tb_cache_snoop_resp;
  import smp_pkg::*;

  localparam int INDEX_W = 3;
  localparam int TAG_W   = 8;
  localparam int LINES   = 8;
  localparam int BUDGET  = 60;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   snoop_req = 1'b0;
  logic [12:0]            snoop_addr = '0;
  logic                   snoop_inv = 1'b0;
  logic                   snoop_ack, snoop_found, snoop_busy;
  logic [1:0]             snoop_state;
  logic [15:0]            snoop_data;
  logic                   lk_re;
  logic [INDEX_W-1:0]     lk_idx;
  logic [TAG_W-1:0]       lk_tag;
  logic [1:0]             lk_state;
  logic [63:0]            lk_line;
  logic                   upd_we;
  logic [INDEX_W-1:0]     upd_idx;
  logic [1:0]             upd_state;
  logic                   wb_req;
  logic [10:0]            wb_addr;
  logic [63:0]            wb_line;
  logic                   wb_rdy = 1'b0;

  always #5 clk = ~clk;

  cache_snoop_resp #(.INDEX_W(INDEX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .snoop_req(snoop_req), .snoop_addr(snoop_addr), .snoop_inv(snoop_inv),
    .snoop_ack(snoop_ack), .snoop_found(snoop_found), .snoop_state(snoop_state),
    .snoop_data(snoop_data), .snoop_busy(snoop_busy),
    .lk_re(lk_re), .lk_idx(lk_idx), .lk_tag(lk_tag), .lk_state(lk_state), .lk_line(lk_line),
    .upd_we(upd_we), .upd_idx(upd_idx), .upd_state(upd_state),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_line(wb_line), .wb_rdy(wb_rdy)
  );

  // Cache arrays: written only by the stimulus process, read here with one-cycle latency.
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [1:0]       st_mem   [LINES];
  logic [63:0]      line_mem [LINES];

  always @(posedge clk) begin
    if (lk_re) begin
      lk_tag   <= tag_mem[lk_idx];
      lk_state <= st_mem[lk_idx];
      lk_line  <= line_mem[lk_idx];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [5:0]  lat;
    logic        found;
    logic [1:0]  st;
    logic [15:0] data;
    logic        upd_we;
    logic [2:0]  upd_idx;
    logic [1:0]  upd_st;
    logic        wb_seen;
    logic [10:0] wb_addr;
    logic [63:0] wb_line;
    logic        wb_stable;
    logic        busy_ok;
    logic        busy_after;
  } resp_t;

  function automatic string fmt(input resp_t r);
    return $sformatf("lat=%0d found=%0b st=%0d data=%h upd=%0b/%0d/%0d wb=%0b/%h/%h stable=%0b busy=%0b/%0b",
                     r.lat, r.found, r.st, r.data, r.upd_we, r.upd_idx, r.upd_st,
                     r.wb_seen, r.wb_addr, r.wb_line, r.wb_stable, r.busy_ok, r.busy_after);
  endfunction

  // Reference: MSI snoop rules applied to the bench's cache contents.
  // d = cycles between the first write-back cycle and the wb_rdy pulse.
  function automatic resp_t model(input logic [12:0] a, input logic inv, input int d);
    resp_t       r;
    int          idx, w, tag;
    logic        hit;
    logic [63:0] sh;
    r = '0;
    idx = (int'(a) / 4) % LINES;
    w   = int'(a) % 4;
    tag = int'(a) / (4 * LINES);
    hit = (st_mem[idx] != 2'd0) && (int'(tag_mem[idx]) == tag);
    r.lat = 6'd2;
    r.wb_stable = 1'b1;
    r.busy_ok = 1'b1;
    r.busy_after = 1'b0;
    if (hit) begin
      sh = line_mem[idx] >> (16 * w);
      r.found = 1'b1;
      r.st = st_mem[idx];
      r.data = sh[15:0];
      if (st_mem[idx] == 2'd2) begin
        r.wb_seen = 1'b1;
        r.wb_addr = a[12:2];
        r.wb_line = line_mem[idx];
        r.lat = 6'(3 + d);
      end
      if (inv || st_mem[idx] == 2'd2) begin
        r.upd_we = 1'b1;
        r.upd_idx = 3'(idx);
        r.upd_st = inv ? 2'd0 : 2'd1;
      end
    end
    return r;
  endfunction

  // Drives one snoop and records what the DUT did; returns one cycle after ack.
  task automatic run_snoop(input logic [12:0] a, input logic inv, input int d,
                           input bit scramble, output resp_t o);
    int wb_first;
    bit done;
    o = '0;
    o.wb_stable = 1'b1;
    o.busy_ok = 1'b1;
    wb_first = -1;
    done = 1'b0;
    @(posedge clk); #1;
    snoop_req = 1'b1; snoop_addr = a; snoop_inv = inv;
    for (int n = 1; n <= BUDGET && !done; n++) begin
      @(posedge clk); #1;
      if (scramble) begin snoop_addr = 13'($urandom); snoop_inv = 1'($urandom); end
      wb_rdy = 1'b0;
      if (!snoop_busy) o.busy_ok = 1'b0;
      if (wb_req) begin
        if (wb_first < 0) begin
          wb_first = n; o.wb_seen = 1'b1; o.wb_addr = wb_addr; o.wb_line = wb_line;
        end else if (wb_addr !== o.wb_addr || wb_line !== o.wb_line) begin
          o.wb_stable = 1'b0;
        end
        if (n == wb_first + d) wb_rdy = 1'b1;
      end
      if (snoop_ack) begin
        o.lat = 6'(n); o.found = snoop_found; o.st = snoop_state; o.data = snoop_data;
        o.upd_we = upd_we; o.upd_idx = upd_idx; o.upd_st = upd_state;
        if (upd_we) st_mem[upd_idx] = upd_state;
        snoop_req = 1'b0;
        done = 1'b1;
      end
    end
    wb_rdy = 1'b0;
    snoop_req = 1'b0;
    if (done) begin
      @(posedge clk); #1;
      o.busy_after = snoop_busy;
    end else begin
      o.busy_after = 1'b1;
    end
  endtask

  task automatic load(input int idx, input logic [7:0] tag, input logic [1:0] st, input logic [63:0] line);
    tag_mem[idx] = tag; st_mem[idx] = st; line_mem[idx] = line;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({snoop_ack, snoop_found, snoop_state, snoop_data, snoop_busy, lk_re, lk_idx,
         upd_we, upd_idx, upd_state, wb_req, wb_addr, wb_line} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ack=%0b busy=%0b wb_req=%0b upd_we=%0b lk_re=%0b, want all 0",
               snoop_ack, snoop_busy, wb_req, upd_we, lk_re);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_miss();
    resp_t o, e;
    load(1, 8'h05, 2'd0, 64'h4444_3333_2222_1111);
    e = model(13'h0A5, 1'b0, 0);
    run_snoop(13'h0A5, 1'b0, 0, 1'b0, o);
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL miss: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_shared_hit();
    resp_t o, e;
    load(1, 8'h05, 2'd1, 64'h4444_3333_2222_1111);
    e = model(13'h0A5, 1'b0, 0);
    run_snoop(13'h0A5, 1'b0, 0, 1'b0, o);
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL shared_hit: got %s want %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (o.data !== 16'h2222) begin n_bad++; $display("FAIL shared_hit_word: got %h want 2222", o.data); end
  endtask

  task automatic test_modified_hit();
    resp_t o, e;
    load(1, 8'h05, 2'd2, 64'h4444_3333_2222_1111);
    e = model(13'h0A5, 1'b0, 3);
    run_snoop(13'h0A5, 1'b0, 3, 1'b1, o);
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL modified_hit: got %s want %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (o.wb_addr !== 11'h029 || st_mem[1] !== 2'd1) begin
      n_bad++; $display("FAIL modified_downgrade: got wb_addr=%h state=%0d want 029 1", o.wb_addr, st_mem[1]);
    end
    // write-back ready already high in the first write-back cycle
    load(3, 8'h07, 2'd2, 64'hDEAD_BEEF_0123_4567);
    e = model(13'h0EE, 1'b0, 0);
    run_snoop(13'h0EE, 1'b0, 0, 1'b0, o);
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL wb_rdy_early: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_invalidate();
    resp_t o, e;
    load(1, 8'h05, 2'd1, 64'h4444_3333_2222_1111);
    e = model(13'h0A5, 1'b1, 0);
    run_snoop(13'h0A5, 1'b1, 0, 1'b0, o);
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL inv_shared: got %s want %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (st_mem[1] !== 2'd0) begin n_bad++; $display("FAIL inv_state: got %0d want 0", st_mem[1]); end
    load(1, 8'h05, 2'd1, 64'h4444_3333_2222_1111);
    e = model(13'h0C5, 1'b1, 0);
    run_snoop(13'h0C5, 1'b1, 0, 1'b0, o);
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL inv_tag_mismatch: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_reset_mid_wb();
    resp_t o, e;
    bit seen;
    load(1, 8'h05, 2'd2, 64'h4444_3333_2222_1111);
    seen = 1'b0;
    @(posedge clk); #1;
    snoop_req = 1'b1; snoop_addr = 13'h0A5; snoop_inv = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk); #1;
      seen = wb_req;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL rst_wb_start: got wb_req=0 want 1"); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({wb_req, snoop_busy, snoop_ack, upd_we} !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_mid_wb: got wb_req=%0b busy=%0b ack=%0b upd_we=%0b want 0000",
               wb_req, snoop_busy, snoop_ack, upd_we);
    end
    snoop_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    e = model(13'h0A5, 1'b0, 1);
    run_snoop(13'h0A5, 1'b0, 1, 1'b0, o);
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL rst_reissue: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_back_to_back();
    int acks[2];
    int n_ack;
    logic found2;
    load(2, 8'h03, 2'd1, 64'h0BAD_F00D_CAFE_1234);
    acks = '{0, 0};
    n_ack = 0;
    found2 = 1'bx;
    @(posedge clk); #1;
    snoop_req = 1'b1; snoop_addr = 13'h06A; snoop_inv = 1'b1;
    for (int n = 1; n <= BUDGET && n_ack < 2; n++) begin
      @(posedge clk); #1;
      if (n_ack == 1 && n == acks[0] + 2) snoop_req = 1'b0;
      if (snoop_ack) begin
        acks[n_ack] = n;
        if (n_ack == 1) found2 = snoop_found;
        if (upd_we) st_mem[upd_idx] = upd_state;
        n_ack++;
      end
    end
    snoop_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (acks[0] != 2) begin n_bad++; $display("FAIL b2b_first_ack: got cycle %0d want 2", acks[0]); end
    n_cmp++;
    if (acks[1] != 5) begin n_bad++; $display("FAIL b2b_second_ack: got cycle %0d want 5", acks[1]); end
    n_cmp++;
    if (found2 !== 1'b0) begin n_bad++; $display("FAIL b2b_sees_invalidate: got found=%0b want 0", found2); end
  endtask

  task automatic test_random();
    resp_t o, e;
    int idx, w, d;
    logic [7:0] tag;
    logic [12:0] a;
    logic inv;
    logic [1:0] exp_st;
    for (int i = 0; i < 60; i++) begin
      idx = int'($urandom_range(LINES - 1));
      w   = int'($urandom_range(3));
      d   = int'($urandom_range(4));
      tag = ($urandom_range(1) == 0) ? 8'h05 : 8'h06;
      inv = 1'($urandom);
      if ($urandom_range(1) == 0)
        load(idx, ($urandom_range(1) == 0) ? 8'h05 : 8'h06, 2'($urandom_range(2)),
             {$urandom, $urandom});
      a = 13'(int'(tag) * 32 + idx * 4 + w);
      e = model(a, inv, d);
      exp_st = e.upd_we ? e.upd_st : st_mem[idx];
      run_snoop(a, inv, d, 1'b1, o);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL random_%0d: got %s want %s", i, fmt(o), fmt(e)); end
      n_cmp++;
      if (st_mem[idx] !== exp_st) begin
        n_bad++; $display("FAIL random_state_%0d: got %0d want %0d", i, st_mem[idx], exp_st);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < LINES; i++) load(i, 8'h00, 2'd0, 64'h0);
    test_reset();
    test_miss();
    test_shared_hit();
    test_modified_hit();
    test_invalidate();
    test_reset_mid_wb();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
